// File: rtl/cpu_pkg.sv
`default_nettype none
// =====================================================================
// cpu_pkg : shared widths, reset PC and fetch FSM encoding
// Rev 1.0
// =====================================================================
package cpu_pkg;

  localparam int          CPU_ADDR_W   = 16;
  localparam int          CPU_DATA_W   = 16;
  localparam logic [15:0] CPU_RESET_PC = 16'h0000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// =====================================================================
// prefetch_fifo : DEPTH-entry in-order word queue with flush
// Rev 1.0
// =====================================================================
module prefetch_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (push && !pop)      r_count <= r_count + CNT_W'(1);
      else if (pop && !push) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= din;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// =====================================================================
// fetch_unit : program counter and instruction prefetch stage
// Rev 1.0
// =====================================================================
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                DATA_W   = CPU_DATA_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_increment,
  input  logic              pc_load,
  input  logic [DATA_W-1:0] d_bus,
  output logic [DATA_W-1:0] i_bus,
  output logic              i_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata
);

  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_discard;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_n;
  logic [DATA_W-1:0] w_head;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_fetch_n;
  logic              w_inc;
  logic              w_empty;
  logic              w_ack;
  logic              w_push;
  logic              w_pop;

  assign w_target = ADDR_W'(d_bus);
  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_inc    = pc_increment & ~pc_load;
  assign w_empty  = (w_count == '0);
  assign w_ack    = (r_state == REQ) & imem_ack;
  // A word acked alongside a load, or while advancing past an empty queue, belongs to a stale PC.
  assign w_push   = w_ack & ~r_discard & ~pc_load & ~(w_inc & w_empty);
  assign w_pop    = w_inc & ~w_empty;

  always_comb begin
    w_count_n = w_count;
    if (pc_load)               w_count_n = '0;
    else if (w_push && !w_pop) w_count_n = w_count + CNT_W'(1);
    else if (w_pop && !w_push) w_count_n = w_count - CNT_W'(1);
  end

  always_comb begin
    w_fetch_n = r_fetch_addr;
    if (pc_load)               w_fetch_n = w_target;
    else if (w_inc && w_empty) w_fetch_n = w_pc_inc;
    else if (w_push)           w_fetch_n = r_fetch_addr + ADDR_W'(1);
  end

  prefetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (pc_load),
    .din   (imem_rdata),
    .head  (w_head),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_fetch_addr <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_discard    <= 1'b0;
    end else begin
      r_fetch_addr <= w_fetch_n;
      if (pc_load)    r_pc <= w_target;
      else if (w_inc) r_pc <= w_pc_inc;

      // An outstanding request still completes; its data is dropped on arrival.
      if (pc_load || (w_inc && w_empty)) r_discard <= (r_state == REQ) && !imem_ack;
      else if (w_ack)                    r_discard <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_count < c_depth) begin
            r_state    <= REQ;
            r_req_addr <= w_fetch_n;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (w_count_n < c_depth) r_req_addr <= w_fetch_n;
            else                     r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pc        = r_pc;
  assign imem_req  = (r_state == REQ);
  assign imem_addr = r_req_addr;
  assign i_valid   = ~w_empty;
  assign i_bus     = i_valid ? w_head : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// =====================================================================
// tb_fetch_unit : scoreboard bench for the fetch stage
// Rev 1.0
// =====================================================================
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_increment = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] d_bus = '0;
  logic [15:0] i_bus;
  logic        i_valid;
  logic [15:0] pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .DEPTH    (2),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_increment (pc_increment),
    .pc_load      (pc_load),
    .d_bus        (d_bus),
    .i_bus        (i_bus),
    .i_valid      (i_valid),
    .pc           (pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] mem [0:65535];
  logic [15:0] m_pc = RESET_PC;
  logic [15:0] ack_log[$];
  int          errors = 0;
  int          checks = 0;
  int          age = 0;
  int          fixed_lat = 0;
  bit          rand_lat = 1'b0;
  bit          prev_req = 1'b0;
  logic [15:0] prev_addr = '0;
  int          wait_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control-unit action: one strobe cycle, then the model PC and the expected presentation.
  task automatic issue(input bit inc, input bit ld, input logic [15:0] tgt);
    pc_increment = inc;
    pc_load      = ld;
    d_bus        = tgt;
    @(posedge clk); #1;
    pc_increment = 1'b0;
    pc_load      = 1'b0;
    if (ld)       m_pc = tgt;
    else if (inc) m_pc = m_pc + 16'd1;
    if (inc || ld) begin
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      exp_q.push_back({m_pc, mem[m_pc]});
      age = 0;
    end
    @(negedge clk);
  endtask

  // Instruction memory with per-request wait states.
  always begin
    @(posedge clk); #1;
    if (!rst_n) begin
      imem_ack = 1'b0;
      prev_req = 1'b0;
    end else begin
      if (prev_req && !imem_ack) begin
        check("req_held", imem_req, 1);
        check("addr_held", imem_addr, prev_addr);
      end
      if (imem_ack) ack_log.push_back(prev_addr);
      if (imem_req && (!prev_req || imem_ack))
        wait_cnt = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
      imem_ack = 1'b0;
      if (imem_req) begin
        if (wait_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
        end else begin
          wait_cnt--;
        end
      end
      prev_req  = imem_req;
      prev_addr = imem_addr;
    end
  end

  // Monitor: pops an expectation whenever the DUT presents a valid word.
  always @(negedge clk) begin
    if (rst_n) begin
      check("pc_track", pc, m_pc);
      if (!i_valid) check("ibus_zero_when_invalid", i_bus, 0);
      if (exp_q.size() > 0) begin
        if (i_valid) begin
          mon_e = exp_q.pop_front();
          check("present_pc", pc, mon_e.pc);
          check("present_word", i_bus, mon_e.word);
          age = 0;
        end else begin
          age++;
          if (age > 60) begin
            check("present_timeout", i_valid, 1);
            exp_q.delete();
            age = 0;
          end
        end
      end
    end
  end

  initial begin
    bit          ok;
    int          r;
    logic [15:0] tgt;

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hFF1A;
    mem[1] = 16'h1234;

    // Reset release with zero-wait memory
    repeat (3) @(negedge clk);
    check("reset_ivalid", i_valid, 0);
    check("reset_ibus", i_bus, 0);
    check("reset_req", imem_req, 0);
    check("reset_pc", pc, RESET_PC);
    check("reset_addr", imem_addr, RESET_PC);
    exp_q.push_back({RESET_PC, mem[RESET_PC]});
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("ivalid_by_cycle2", i_valid, 1);
    check("ibus_cycle2", i_bus, 16'hFF1A);
    @(negedge clk);
    check("req_drop_full", imem_req, 0);
    repeat (3) @(negedge clk);
    check("req_stays_idle", imem_req, 0);

    // Literal sequence, then load while the request for address 2 is outstanding
    fixed_lat = 3;
    issue(1'b1, 1'b0, 16'h0);
    check("lit_pc1", pc, 16'd1);
    check("lit_word1", i_bus, 16'h1234);
    issue(1'b1, 1'b0, 16'h0);
    check("lit_pc2", pc, 16'd2);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (imem_req && imem_addr == 16'd2 && !imem_ack) ok = 1'b1;
      else @(negedge clk);
    end
    check("req2_outstanding", ok, 1);
    ack_log.delete();
    issue(1'b0, 1'b1, 16'h0040);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (imem_req && imem_addr != 16'd2) ok = 1'b1;
      else @(negedge clk);
    end
    check("post_load_req_seen", ok, 1);
    check("post_load_addr", imem_addr, 16'h0040);
    check("discarded_req_done", (ack_log.size() > 0) ? 32'(ack_log[0]) : 32'hFFFF_FFFF, 2);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (i_valid) ok = 1'b1;
      else @(negedge clk);
    end
    check("load_valid", ok, 1);
    check("load_word", i_bus, mem[16'h0040]);
    check("load_pc", pc, 16'h0040);

    // Simultaneous load and increment: load wins, queue flushed
    issue(1'b1, 1'b1, 16'h0100);
    check("ld_inc_pc", pc, 16'h0100);
    check("ld_flush", i_valid, 0);

    // Wrap-around at 16'hFFFF
    fixed_lat = 0;
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      if (i_valid && !imem_req) ok = 1'b1;
      else @(negedge clk);
    end
    check("settle_before_wrap", ok, 1);
    ack_log.delete();
    issue(1'b0, 1'b1, 16'hFFFF);
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      if (i_valid && !imem_req) ok = 1'b1;
      else @(negedge clk);
    end
    check("wrap_fill", ok, 1);
    check("wrap_word_ffff", i_bus, mem[16'hFFFF]);
    issue(1'b1, 1'b0, 16'h0);
    check("wrap_pc", pc, 16'h0000);
    check("wrap_word_0", i_bus, mem[16'h0000]);
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      if (ack_log.size() >= 3 && !imem_req) ok = 1'b1;
      else @(negedge clk);
    end
    check("wrap_refill", ok, 1);
    check("wrap_addr0", (ack_log.size() > 0) ? 32'(ack_log[0]) : 32'hFFFF_FFFF, 16'hFFFF);
    check("wrap_addr1", (ack_log.size() > 1) ? 32'(ack_log[1]) : 32'hFFFF_FFFF, 16'h0000);
    check("wrap_addr2", (ack_log.size() > 2) ? 32'(ack_log[2]) : 32'hFFFF_FFFF, 16'h0001);

    // Reset asserted mid-handshake
    fixed_lat = 6;
    issue(1'b0, 1'b1, 16'h0200);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (imem_req && !imem_ack) ok = 1'b1;
      else @(negedge clk);
    end
    check("pending_before_reset", ok, 1);
    #2;
    rst_n = 1'b0;
    m_pc  = RESET_PC;
    exp_q.delete();
    age   = 0;
    #1;
    check("midreset_req", imem_req, 0);
    check("midreset_ivalid", i_valid, 0);
    check("midreset_ibus", i_bus, 0);
    check("midreset_pc", pc, RESET_PC);
    check("midreset_addr", imem_addr, RESET_PC);
    @(negedge clk); @(negedge clk);
    #2;
    rst_n = 1'b1;
    exp_q.push_back({RESET_PC, mem[RESET_PC]});
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(negedge clk);
      if (imem_req) ok = 1'b1;
    end
    check("req_after_reset", ok, 1);
    check("first_req_addr", imem_addr, RESET_PC);

    // Randomised control-unit traffic against random memory latency
    rand_lat = 1'b1;
    for (int k = 0; k < 400; k++) begin
      r  = int'($urandom_range(0, 99));
      ok = i_valid || ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0:       tgt = 16'($urandom);
        1:       tgt = 16'hFFFE + 16'($urandom_range(0, 1));
        default: tgt = 16'($urandom_range(0, 15));
      endcase
      if (ok && r < 55)      issue(1'b1, 1'b0, 16'h0);
      else if (ok && r < 65) issue(1'b0, 1'b1, tgt);
      else if (ok && r < 70) issue(1'b1, 1'b1, tgt);
      else                   @(negedge clk);
    end

    for (int n = 0; n < 80 && exp_q.size() > 0; n++) @(negedge clk);
    check("final_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program counter and instruction prefetch stage. Sits directly upstream of the control unit.
- Holds the PC and fetches instruction words from instruction memory over a req/ack handshake.
- Keeps a small prefetch queue so that i_bus always presents the word at the current PC, which the control unit samples as an opcode or as a literal.
- Consumes the pc_increment / pc_load strobes from the control unit; the jump target is taken from d_bus.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width
- DATA_W, 16, instruction word width
- DEPTH, 2, prefetch queue entries (power of two, >=2)
- RESET_PC, 16'h0000, PC value after reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc_increment  in  1  advance PC by one (one-cycle strobe from control unit)
- pc_load  in  1  load PC from d_bus
- d_bus  in  DATA_W  jump target, sampled when pc_load=1
- i_bus  out  DATA_W  instruction word at current PC (head of queue)
- i_valid  out  1  i_bus holds the word for the current PC
- pc  out  ADDR_W  current program counter
- imem_req  out  1  instruction-memory request
- imem_addr  out  ADDR_W  request address
- imem_ack  in  1  memory accepts the request; imem_rdata is valid this same cycle
- imem_rdata  in  DATA_W  returned instruction word

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, fetch_addr=RESET_PC, queue empty.
  - i_valid=0, i_bus=0, imem_req=0, imem_addr=RESET_PC, discard flag=0.
  - Reset asserted mid-handshake abandons the request. The first request after release is RESET_PC.
- Queue:
  - DEPTH entries, in-order words for addresses pc, pc+1, ...
  - i_bus = head entry when i_valid, else 0. i_valid = (count!=0).
- Fetch FSM states:
  - IDLE: go to REQ when count + in-flight < DEPTH.
  - REQ: imem_req=1, imem_addr=fetch_addr. Both are held stable until imem_ack.
  - On ack: if the discard flag is clear, push imem_rdata and increment fetch_addr; if set, drop the data and clear the flag. Go to REQ if space remains, else IDLE. Back-to-back requests are permitted: REQ→REQ on ack.
- Latency: with zero-wait memory (ack tied 1), i_valid rises 2 cycles after reset release or after a load.
- pc_increment (no load):
  - pc<=pc+1 and the queue pops its head.
  - If the queue is empty: pc still advances, and the next useful fetch is for the new pc. Any in-flight request for the old pc is marked discard, and fetch_addr<=pc+1.
- pc_load:
  - pc<=d_bus and the queue is flushed (count=0). fetch_addr<=d_bus.
  - If a request is outstanding (REQ and not acked this cycle), set discard. The request completes unchanged, then the FSM issues d_bus.
- Simultaneous pc_load and pc_increment: load wins; the increment is ignored.
- Push and pop in the same cycle: count unchanged; the head advances and the new word is appended.
- An ack arriving in the same cycle as pc_load is treated as discarded.
- Wrap-around: pc, fetch_addr and queue pointers wrap modulo 2^ADDR_W / DEPTH. 16'hFFFF+1 = 16'h0000 with no error.
- Never request beyond DEPTH outstanding+buffered. Never push while full.

Decomposition:
- Shared package cpu_pkg holds ADDR_W/DATA_W defaults, RESET_PC, and the fetch FSM state encoding (localparams IDLE=0, REQ=1).
- One natural sub-module: prefetch_fifo, a DEPTH-entry synchronous FIFO with push/pop/flush/count and a combinational head output.
- PC, fetch_addr, discard flag and FSM live in fetch_unit.

Test Plan:
- Reset release, ack tied 1, mem[0]=16'hFF1A, mem[1]=16'h1234:
  - i_valid=1 with i_bus=FF1A by cycle 2; pc=0.
  - Then imem_req drops once 2 words are buffered.
- Literal sequence (pc_increment pulse at pc=0, another at pc=1):
  - i_bus shows 1234 after the first pulse; pc=1, then 2.
  - No duplicate or skipped words.
- Memory with 3-cycle ack latency, pc_load with d_bus=16'h0040 while the request for addr 2 is outstanding:
  - The request for 2 completes and is discarded.
  - The next imem_addr is 0040.
  - i_bus=mem[0x40], pc=0040.
- pc_load and pc_increment in the same cycle, d_bus=16'h0100: pc=0100, not 0101; the queue is flushed.
- pc=16'hFFFF with pc_increment: pc=0000, and the prefetch addresses wrap to 0000 and 0001.
- Assert rst_n low while imem_req=1 and ack withheld:
  - Outputs return to reset values immediately.
  - The first request after release is RESET_PC.
